// File: rtl/framestore_request_pkg.sv
// Shared memory command/tag codes and client indexing for the frame store request path.
// The command and tag encodings must match the response path that decodes them.
package framestore_request_pkg;

    localparam logic [1:0] CMD_NOOP    = 2'd0;
    localparam logic [1:0] CMD_REFRESH = 2'd1;
    localparam logic [1:0] CMD_READ    = 2'd2;
    localparam logic [1:0] CMD_WRITE   = 2'd3;

    localparam logic [2:0] TAG_NONE = 3'd0;
    localparam logic [2:0] TAG_FWD  = 3'd1;
    localparam logic [2:0] TAG_BWD  = 3'd2;
    localparam logic [2:0] TAG_DISP = 3'd3;
    localparam logic [2:0] TAG_VBUF = 3'd4;

    localparam int ADDR_W      = 22;
    localparam int DATA_W      = 64;
    localparam int NUM_CLIENTS = 6;

    // Bit index doubles as priority: lower index wins arbitration.
    localparam int CL_DISP  = 0;
    localparam int CL_FWD   = 1;
    localparam int CL_BWD   = 2;
    localparam int CL_RECON = 3;
    localparam int CL_VBW   = 4;
    localparam int CL_VBR   = 5;

    typedef logic [NUM_CLIENTS-1:0] client_vec_t;

    localparam client_vec_t READ_MASK = client_vec_t'((1 << CL_DISP) | (1 << CL_FWD)
                                                    | (1 << CL_BWD) | (1 << CL_VBR));

    typedef enum logic [1:0] {
        ST_INIT,
        ST_WAIT,
        ST_GRANT,
        ST_ISSUE
    } state_e;

    function automatic logic grant_is_read(input client_vec_t grant);
        return |(grant & READ_MASK);
    endfunction

    function automatic logic [2:0] client_tag(input client_vec_t grant);
        logic [2:0] tag;
        tag = TAG_NONE;
        if (grant[CL_FWD])  tag = TAG_FWD;
        if (grant[CL_BWD])  tag = TAG_BWD;
        if (grant[CL_DISP]) tag = TAG_DISP;
        if (grant[CL_VBR])  tag = TAG_VBUF;
        return tag;
    endfunction

endpackage

// File: rtl/framestore_request_arbiter.sv
// Combinational fixed-priority encoder: the lowest set bit of the eligibility vector wins.
module framestore_request_arbiter
    import framestore_request_pkg::*;
(
    input  client_vec_t eligible,
    output client_vec_t grant,
    output logic        any_grant
);

    // Two's-complement trick isolates the lowest set bit as a one-hot grant.
    always_comb begin
        grant     = eligible & (~eligible + client_vec_t'(1));
        any_grant = |eligible;
    end

endmodule

// File: rtl/framestore_request.sv
// Frame store request side: arbitrates six clients into the memory request fifo and
// pushes a routing tag for every read so the response path can steer returned data.
module framestore_request
    import framestore_request_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = 65536
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] fwd_rd_addr,
    input  logic              fwd_rd_addr_empty,
    input  logic              fwd_rd_addr_valid,
    output logic              fwd_rd_addr_en,
    input  logic              fwd_wr_dta_almost_full,

    input  logic [ADDR_W-1:0] bwd_rd_addr,
    input  logic              bwd_rd_addr_empty,
    input  logic              bwd_rd_addr_valid,
    output logic              bwd_rd_addr_en,
    input  logic              bwd_wr_dta_almost_full,

    input  logic [ADDR_W-1:0] disp_rd_addr,
    input  logic              disp_rd_addr_empty,
    input  logic              disp_rd_addr_valid,
    output logic              disp_rd_addr_en,
    input  logic              disp_wr_dta_almost_full,

    input  logic [ADDR_W-1:0] vbr_rd_addr,
    input  logic              vbr_rd_addr_empty,
    input  logic              vbr_rd_addr_valid,
    output logic              vbr_rd_addr_en,
    input  logic              vbr_wr_dta_almost_full,

    input  logic [ADDR_W-1:0] recon_wr_addr,
    input  logic [DATA_W-1:0] recon_wr_dta,
    input  logic              recon_wr_empty,
    input  logic              recon_wr_valid,
    output logic              recon_wr_en,

    input  logic [ADDR_W-1:0] vbw_wr_addr,
    input  logic [DATA_W-1:0] vbw_wr_dta,
    input  logic              vbw_wr_empty,
    input  logic              vbw_wr_valid,
    output logic              vbw_wr_en,

    output logic [1:0]        mem_req_wr_cmd,
    output logic [ADDR_W-1:0] mem_req_wr_addr,
    output logic [DATA_W-1:0] mem_req_wr_dta,
    output logic              mem_req_wr_en,
    input  logic              mem_req_wr_almost_full,

    output logic [2:0]        tag_wr_dta,
    output logic              tag_wr_en,
    input  logic              tag_wr_almost_full
);

    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    client_vec_t       grant_q, grant_d;
    client_vec_t       en_q, en_d;
    logic [1:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dta_q, dta_d;
    logic              mem_en_q, mem_en_d;
    logic [2:0]        tag_q, tag_d;
    logic              tag_en_q, tag_en_d;

    client_vec_t       eligible;
    client_vec_t       valid_vec;
    client_vec_t       arb_grant;
    logic              arb_any;
    logic [ADDR_W-1:0] client_addr [NUM_CLIENTS];
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_dta;
    logic              sel_valid;

    // Reads are held back while their destination fifo is nearly full; writes only need data.
    assign eligible[CL_DISP]  = ~disp_rd_addr_empty & ~disp_wr_dta_almost_full;
    assign eligible[CL_FWD]   = ~fwd_rd_addr_empty  & ~fwd_wr_dta_almost_full;
    assign eligible[CL_BWD]   = ~bwd_rd_addr_empty  & ~bwd_wr_dta_almost_full;
    assign eligible[CL_RECON] = ~recon_wr_empty;
    assign eligible[CL_VBW]   = ~vbw_wr_empty;
    assign eligible[CL_VBR]   = ~vbr_rd_addr_empty  & ~vbr_wr_dta_almost_full;

    assign valid_vec[CL_DISP]  = disp_rd_addr_valid;
    assign valid_vec[CL_FWD]   = fwd_rd_addr_valid;
    assign valid_vec[CL_BWD]   = bwd_rd_addr_valid;
    assign valid_vec[CL_RECON] = recon_wr_valid;
    assign valid_vec[CL_VBW]   = vbw_wr_valid;
    assign valid_vec[CL_VBR]   = vbr_rd_addr_valid;

    assign client_addr[CL_DISP]  = disp_rd_addr;
    assign client_addr[CL_FWD]   = fwd_rd_addr;
    assign client_addr[CL_BWD]   = bwd_rd_addr;
    assign client_addr[CL_RECON] = recon_wr_addr;
    assign client_addr[CL_VBW]   = vbw_wr_addr;
    assign client_addr[CL_VBR]   = vbr_rd_addr;

    framestore_request_arbiter u_arbiter (
        .eligible  (eligible),
        .grant     (arb_grant),
        .any_grant (arb_any)
    );

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_q[i]) sel_addr = client_addr[i];
        end
        sel_dta   = grant_q[CL_VBW] ? vbw_wr_dta : recon_wr_dta;
        sel_valid = |(grant_q & valid_vec);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        en_d     = '0;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        dta_d    = dta_q;
        mem_en_d = 1'b0;
        tag_d    = tag_q;
        tag_en_d = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (cnt_q == INIT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (!mem_req_wr_almost_full && !tag_wr_almost_full && arb_any) begin
                    grant_d = arb_grant;
                    en_d    = arb_grant;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // A missing _valid means the client fifo had nothing after all; drop silently.
                if (sel_valid) begin
                    mem_en_d = 1'b1;
                    addr_d   = sel_addr;
                    if (grant_is_read(grant_q)) begin
                        cmd_d    = CMD_READ;
                        dta_d    = '0;
                        tag_d    = client_tag(grant_q);
                        tag_en_d = 1'b1;
                    end else begin
                        cmd_d = CMD_WRITE;
                        dta_d = sel_dta;
                    end
                end
                grant_d = '0;
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            cnt_q    <= '0;
            grant_q  <= '0;
            en_q     <= '0;
            cmd_q    <= CMD_NOOP;
            addr_q   <= '0;
            dta_q    <= '0;
            mem_en_q <= 1'b0;
            tag_q    <= '0;
            tag_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            en_q     <= en_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            dta_q    <= dta_d;
            mem_en_q <= mem_en_d;
            tag_q    <= tag_d;
            tag_en_q <= tag_en_d;
        end
    end

    assign disp_rd_addr_en = en_q[CL_DISP];
    assign fwd_rd_addr_en  = en_q[CL_FWD];
    assign bwd_rd_addr_en  = en_q[CL_BWD];
    assign recon_wr_en     = en_q[CL_RECON];
    assign vbw_wr_en       = en_q[CL_VBW];
    assign vbr_rd_addr_en  = en_q[CL_VBR];

    assign mem_req_wr_cmd  = cmd_q;
    assign mem_req_wr_addr = addr_q;
    assign mem_req_wr_dta  = dta_q;
    assign mem_req_wr_en   = mem_en_q;
    assign tag_wr_dta      = tag_q;
    assign tag_wr_en       = tag_en_q;

endmodule

// File: tb/tb_framestore_request.sv
// Scoreboard bench for framestore_request: client fifo models feed the DUT, expected
// memory requests are queued at stimulus time and popped by an independent monitor.
module tb_framestore_request;

    localparam int INIT_N = 16;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [21:0] addr;
        logic [63:0] dta;
        logic        tag_en;
        logic [2:0]  tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Client fifo models: index 0 disp, 1 fwd, 2 bwd, 3 recon, 4 vbw, 5 vbr
    logic [21:0] c_addr [6][8];
    logic [63:0] c_dta  [6][8];
    int          wp [6];
    int          rp [6];
    logic [5:0]  force_ne;
    logic [5:0]  c_empty;
    logic [5:0]  c_vld = '0;
    logic [5:0]  c_en;
    logic [21:0] c_out_addr [6];
    logic [63:0] c_out_dta  [6];
    logic [3:0]  rd_af;
    logic        mem_af;
    logic        tag_af;

    logic disp_en, fwd_en, bwd_en, recon_en, vbw_en, vbr_en;
    logic [1:0]  mem_req_wr_cmd;
    logic [21:0] mem_req_wr_addr;
    logic [63:0] mem_req_wr_dta;
    logic        mem_req_wr_en;
    logic [2:0]  tag_wr_dta;
    logic        tag_wr_en;

    assign c_en = {vbr_en, vbw_en, recon_en, bwd_en, fwd_en, disp_en};

    always_comb begin
        c_empty = '0;
        for (int i = 0; i < 6; i++) c_empty[i] = (wp[i] == rp[i]) && !force_ne[i];
    end

    always @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (c_en[i] && (wp[i] != rp[i])) begin
                c_vld[i]      <= 1'b1;
                c_out_addr[i] <= c_addr[i][rp[i] % 8];
                c_out_dta[i]  <= c_dta[i][rp[i] % 8];
                rp[i]         <= rp[i] + 1;
            end else begin
                c_vld[i] <= 1'b0;
            end
        end
    end

    framestore_request #(.INIT_CYCLES(INIT_N)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .fwd_rd_addr             (c_out_addr[1]),
        .fwd_rd_addr_empty       (c_empty[1]),
        .fwd_rd_addr_valid       (c_vld[1]),
        .fwd_rd_addr_en          (fwd_en),
        .fwd_wr_dta_almost_full  (rd_af[1]),
        .bwd_rd_addr             (c_out_addr[2]),
        .bwd_rd_addr_empty       (c_empty[2]),
        .bwd_rd_addr_valid       (c_vld[2]),
        .bwd_rd_addr_en          (bwd_en),
        .bwd_wr_dta_almost_full  (rd_af[2]),
        .disp_rd_addr            (c_out_addr[0]),
        .disp_rd_addr_empty      (c_empty[0]),
        .disp_rd_addr_valid      (c_vld[0]),
        .disp_rd_addr_en         (disp_en),
        .disp_wr_dta_almost_full (rd_af[0]),
        .vbr_rd_addr             (c_out_addr[5]),
        .vbr_rd_addr_empty       (c_empty[5]),
        .vbr_rd_addr_valid       (c_vld[5]),
        .vbr_rd_addr_en          (vbr_en),
        .vbr_wr_dta_almost_full  (rd_af[3]),
        .recon_wr_addr           (c_out_addr[3]),
        .recon_wr_dta            (c_out_dta[3]),
        .recon_wr_empty          (c_empty[3]),
        .recon_wr_valid          (c_vld[3]),
        .recon_wr_en             (recon_en),
        .vbw_wr_addr             (c_out_addr[4]),
        .vbw_wr_dta              (c_out_dta[4]),
        .vbw_wr_empty            (c_empty[4]),
        .vbw_wr_valid            (c_vld[4]),
        .vbw_wr_en               (vbw_en),
        .mem_req_wr_cmd          (mem_req_wr_cmd),
        .mem_req_wr_addr         (mem_req_wr_addr),
        .mem_req_wr_dta          (mem_req_wr_dta),
        .mem_req_wr_en           (mem_req_wr_en),
        .mem_req_wr_almost_full  (mem_af),
        .tag_wr_dta              (tag_wr_dta),
        .tag_wr_en               (tag_wr_en),
        .tag_wr_almost_full      (tag_af)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Loads one entry into a client fifo and, when a push is expected, queues the
    // hand-derived memory request (calls are made in expected grant order).
    task automatic applyStimulus(input int idx, input logic [21:0] addr, input logic [63:0] dta,
                                 input bit expect_push);
        exp_t e;
        c_addr[idx][wp[idx] % 8] = addr;
        c_dta[idx][wp[idx] % 8]  = dta;
        wp[idx] = wp[idx] + 1;
        if (expect_push) begin
            e.addr = addr;
            if (idx == 3 || idx == 4) begin
                e.cmd = 2'd3; e.dta = dta; e.tag_en = 1'b0; e.tag = 3'd0;
            end else begin
                e.cmd = 2'd2; e.dta = 64'd0; e.tag_en = 1'b1;
                case (idx)
                    0:       e.tag = 3'd3;
                    1:       e.tag = 3'd1;
                    2:       e.tag = 3'd2;
                    default: e.tag = 3'd4;
                endcase
            end
            sb.push_back(e);
        end
    endtask

    task automatic waitDrain(input int max_cycles);
        for (int i = 0; i < max_cycles && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tagname);
        checkOutput({tagname, "_en"},     64'(c_en), 64'd0);
        checkOutput({tagname, "_cmd"},    64'(mem_req_wr_cmd), 64'd0);
        checkOutput({tagname, "_addr"},   64'(mem_req_wr_addr), 64'd0);
        checkOutput({tagname, "_dta"},    mem_req_wr_dta, 64'd0);
        checkOutput({tagname, "_tag"},    64'(tag_wr_dta), 64'd0);
        checkOutput({tagname, "_mem_en"}, 64'(mem_req_wr_en), 64'd0);
        checkOutput({tagname, "_tag_en"}, 64'(tag_wr_en), 64'd0);
    endtask

    // Monitor: every push is matched against the head of the scoreboard.
    logic prev_mem_en = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (mem_req_wr_en) begin
            if (prev_mem_en) checkOutput("mem_en_single_pulse", 64'd1, 64'd0);
            if (sb.size() == 0) begin
                checkOutput("unexpected_push", 64'(mem_req_wr_addr), 64'h3FFFFFFFFF);
            end else begin
                e = sb.pop_front();
                checkOutput("push_cmd",    64'(mem_req_wr_cmd), 64'(e.cmd));
                checkOutput("push_addr",   64'(mem_req_wr_addr), 64'(e.addr));
                checkOutput("push_dta",    mem_req_wr_dta, e.dta);
                checkOutput("push_tag_en", 64'(tag_wr_en), 64'(e.tag_en));
                if (e.tag_en) checkOutput("push_tag", 64'(tag_wr_dta), 64'(e.tag));
            end
        end else if (tag_wr_en) begin
            checkOutput("tag_without_mem", 64'd1, 64'd0);
        end
        prev_mem_en <= mem_req_wr_en;
    end

    initial begin
        int first_en, first_mem, en_k, mem_k, en_cnt, cnt, found;
        force_ne = '0;
        rd_af    = '0;
        mem_af   = 1'b0;
        tag_af   = 1'b0;
        rst      = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");

        // All clients pending across reset: priority order disp fwd bwd recon vbw vbr
        applyStimulus(0, 22'h00A01, 64'd0, 1'b1);
        applyStimulus(1, 22'h00B02, 64'd0, 1'b1);
        applyStimulus(2, 22'h00C03, 64'd0, 1'b1);
        applyStimulus(3, 22'h00D04, 64'h1111_2222_3333_4444, 1'b1);
        applyStimulus(4, 22'h00E05, 64'h5555_6666_7777_8888, 1'b1);
        applyStimulus(5, 22'h00F06, 64'd0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        first_en  = 0;
        first_mem = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (c_en != 6'd0 && first_en == 0) first_en = k;
            if (mem_req_wr_en && first_mem == 0) first_mem = k;
        end
        checkOutput("init_first_en",   64'(first_en), 64'd17);
        checkOutput("init_first_push", 64'(first_mem), 64'd19);
        waitDrain(60);

        // Lone fwd read: en pulse, push two cycles later
        applyStimulus(1, 22'h00123, 64'd0, 1'b1);
        en_k = 0; mem_k = 0; en_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (fwd_en) begin
                en_cnt++;
                if (en_k == 0) en_k = k;
            end
            if (mem_req_wr_en && mem_k == 0) mem_k = k;
        end
        checkOutput("fwd_en_to_push", 64'(mem_k - en_k), 64'd2);
        checkOutput("fwd_en_width",   64'(en_cnt), 64'd1);
        waitDrain(20);

        // Recon write at the top of the address range; outputs hold afterwards
        applyStimulus(3, 22'h3FFFFF, 64'hDEADBEEF_01234567, 1'b1);
        waitDrain(20);
        repeat (2) @(negedge clk);
        checkOutput("hold_cmd",    64'(mem_req_wr_cmd), 64'd3);
        checkOutput("hold_addr",   64'(mem_req_wr_addr), 64'h3FFFFF);
        checkOutput("hold_dta",    mem_req_wr_dta, 64'hDEADBEEF_01234567);
        checkOutput("hold_tag_en", 64'(tag_wr_en), 64'd0);

        // disp blocked by its destination almost-full: vbr goes first
        rd_af[0] = 1'b1;
        applyStimulus(5, 22'h02222, 64'd0, 1'b1);
        applyStimulus(0, 22'h01111, 64'd0, 1'b1);
        cnt = 0;
        for (int i = 0; i < 30 && sb.size() > 1; i++) begin
            @(negedge clk);
            if (disp_en) cnt++;
        end
        repeat (3) @(negedge clk);
        if (disp_en) cnt++;
        checkOutput("disp_blocked_no_en", 64'(cnt), 64'd0);
        rd_af[0] = 1'b0;
        waitDrain(30);

        // Memory request fifo almost full stalls arbitration
        mem_af = 1'b1;
        applyStimulus(1, 22'h00456, 64'd0, 1'b1);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (c_en != 6'd0) cnt++;
        end
        checkOutput("memaf_no_grant", 64'(cnt), 64'd0);
        mem_af = 1'b0;
        @(negedge clk);
        checkOutput("memaf_grant_after_release", 64'(fwd_en), 64'd1);
        waitDrain(20);

        // Tag fifo almost full stalls arbitration as well
        tag_af = 1'b1;
        applyStimulus(2, 22'h00789, 64'd0, 1'b1);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (c_en != 6'd0) cnt++;
        end
        checkOutput("tagaf_no_grant", 64'(cnt), 64'd0);
        tag_af = 1'b0;
        waitDrain(20);

        // Reset asserted while in GRANT: nothing is pushed, INIT restarts
        applyStimulus(0, 22'h03333, 64'd0, 1'b0);
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            @(negedge clk);
            if (disp_en) found = 1;
        end
        checkOutput("grant_seen_before_reset", 64'(found), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        checkResetOutputs("midreset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        applyStimulus(1, 22'h00AAA, 64'd0, 1'b1);
        cnt = 0;
        repeat (INIT_N) begin
            @(negedge clk);
            if (c_en != 6'd0 || mem_req_wr_en) cnt++;
        end
        checkOutput("reinit_quiet", 64'(cnt), 64'd0);
        waitDrain(30);

        // Client claims data but never presents _valid: grants are dropped, nothing pushed
        force_ne[4] = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (vbw_en) cnt++;
        end
        force_ne[4] = 1'b0;
        checkOutput("vbw_drop_pulses", 64'(cnt), 64'd3);
        repeat (6) @(negedge clk);
        checkOutput("scoreboard_empty_end", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
